sid_bus_if: RTL and testbench
=============================

Name: sid_bus_if

Overview:
Parametrised next-generation 6502-bus interface for the SID core. Synchronises the raw bus pins and derives the 1 MHz clock enable from the phi2 rising edge. Decodes N chip selects so one FPGA hosts multiple SID instances. Queues bus writes in a small FIFO with a valid/ready handshake toward the SID write port, and drives read data back onto the bus.

Parameters:
DATA_W, 8, bus data width
ADDR_W, 5, register address width
N_CS, 2, number of active-low chip selects / SID instances (1..4)
SYNC_STAGES, 2, synchroniser depth for all bus inputs (>=2)
FIFO_DEPTH, 4, write queue entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
bus_d  in  DATA_W  raw data pins
bus_a  in  ADDR_W  raw address pins
bus_cs_n  in  N_CS  raw chip selects, active low
bus_rw  in  1  raw R/W (1 = read)
bus_phi2  in  1  raw phi2
clken  out  1  one-cycle pulse on phi2 rising edge
wr_valid  out  1  FIFO head valid
wr_ready  in  1  consumer accepts head
wr_chip  out  clog2(N_CS) max 1  head chip index
wr_addr  out  ADDR_W  head address
wr_data  out  DATA_W  head data
rd_chip  out  clog2(N_CS) max 1  chip being read
rd_addr  out  ADDR_W  address being read
rd_data  in  DATA_W  read data from selected SID (combinational source)
bus_d_out  out  DATA_W  data to drive on bus
bus_d_oe  out  1  bus data output enable
overflow  out  1  sticky: write dropped, FIFO full
cs_conflict  out  1  sticky: >1 chip select low at a commit point

Behaviour:
- Reset (async assert, sync deassert handled upstream). Sync chains load idle values: cs_n all 1, rw 1, phi2 0, a/d 0. FIFO empty. All outputs 0 except rd_* = 0.
- Every input passes through SYNC_STAGES flops, followed by one history flop on phi2. rise = s_phi2 & ~h_phi2; fall = ~s_phi2 & h_phi2.
- clken = rise, registered. Latency: pin edge to clken = SYNC_STAGES+1 cycles. No spurious pulse on the first cycles after reset.
- sel = any synced cs_n low. chip = lowest index with cs_n low. cs_conflict sets when more than one cs_n is low on a fall cycle with sel.
- Write commit: on fall & sel & ~s_rw, push {chip, s_a, s_d}, all sampled in the same cycle as fall.
- FIFO: push accepted if not full, or if full and a pop happens in the same cycle (pop-then-push). Otherwise the write is dropped and overflow sets; overflow clears only on rst.
- Pop when wr_valid & wr_ready. Outputs come straight from the head entry. Pointers wrap modulo FIFO_DEPTH and carry an extra wrap bit for full/empty.
- Push into an empty FIFO: wr_valid asserts the next cycle. Payload stays stable while valid & ~ready.
- Read path: rd_chip/rd_addr are registered from chip/s_a every cycle sel & s_rw holds.
- bus_d_oe = s_phi2 & sel & s_rw, registered. It deasserts the cycle after fall or deselect.
- bus_d_out = rd_data, registered while bus_d_oe is asserted. Holds its last value otherwise.
- A read cycle never pushes. A write cycle never asserts oe.
- Reset mid-transaction: FIFO contents are discarded and a partially observed phi2 cycle is ignored. The next commit requires a full rise→fall.

Decomposition:
- Shared package sid_pkg: localparams for CHIP_W = max(1, clog2(N_CS)), the FIFO entry packing order {chip, addr, data}, and the idle levels of the bus signals.
- One natural sub-module: sid_wr_fifo, a parametrised synchronous FIFO with width/depth parameters, push/pop, full/empty and pop-then-push. The sync chains and decode stay in sid_bus_if.

Test Plan:
- Clock enable: phi2 toggling at 1 MHz equivalent (every 24 clk) -> exactly one clken pulse per period, SYNC_STAGES+1 cycles after each rise, none after reset.
- Single write: cs_n=2'b10, rw=0, a=5'h18, d=8'h0F, then phi2 fall -> wr_valid=1 with chip=0, addr=18, data=0F. With wr_ready=1 the entry pops after one cycle.
- Second chip and conflict:
  - cs_n=2'b01 write a=5'h04, d=8'h41 -> chip=1.
  - cs_n=2'b00 write -> chip=0 and cs_conflict=1.
- Backpressure and overflow:
  - wr_ready=0, 5 writes with d=01..05 -> first 4 queued in order, overflow=1, 5th lost.
  - A write on a full-FIFO cycle where wr_ready=1 -> accepted, no overflow.
- Read: cs_n=2'b10, rw=1, a=5'h1B, rd_data=8'hA5, phi2 high -> rd_addr=1B, bus_d_oe=1, bus_d_out=A5. oe drops 1 cycle after the synced fall. No FIFO push.
- Reset mid-operation: rst pulse while phi2 is high with a write pending -> FIFO empty, all flags 0. The next complete write cycle is queued normally.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared constants for the SID bus interface: bus idle levels, chip index width
// and the write-queue entry layout {chip, addr, data} with data in the LSBs.
package sid_pkg;

  localparam logic IDLE_CS_N = 1'b1;
  localparam logic IDLE_RW   = 1'b1;
  localparam logic IDLE_PHI2 = 1'b0;
  localparam logic IDLE_AD   = 1'b0;

  function automatic int unsigned chip_w(input int unsigned n_cs);
    return (n_cs > 1) ? $clog2(n_cs) : 1;
  endfunction

  function automatic int unsigned entry_w(input int unsigned cw, input int unsigned aw,
                                          input int unsigned dw);
    return cw + aw + dw;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned chip_lsb(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only when
// a pop happens in the same cycle.
module sid_wr_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sid_bus_if.sv
// 6502-bus front end for one or more SID cores: synchronises pins, derives the phi2
// clock enable, queues writes toward the SID write port and drives read data back.
module sid_bus_if
  import sid_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned N_CS        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned CHIP_W     = chip_w(N_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_d,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic [N_CS-1:0]   bus_cs_n,
  input  logic              bus_rw,
  input  logic              bus_phi2,
  output logic              clken,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [CHIP_W-1:0] wr_chip,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CHIP_W-1:0] rd_chip,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] bus_d_out,
  output logic              bus_d_oe,
  output logic              overflow,
  output logic              cs_conflict
);

  localparam int unsigned EW = entry_w(CHIP_W, ADDR_W, DATA_W);
  localparam int unsigned AL = addr_lsb(DATA_W);
  localparam int unsigned CL = chip_lsb(ADDR_W, DATA_W);

  logic [DATA_W-1:0] d_sync    [SYNC_STAGES];
  logic [ADDR_W-1:0] a_sync    [SYNC_STAGES];
  logic [N_CS-1:0]   cs_sync   [SYNC_STAGES];
  logic              rw_sync   [SYNC_STAGES];
  logic              phi2_sync [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        d_sync[i]    <= {DATA_W{IDLE_AD}};
        a_sync[i]    <= {ADDR_W{IDLE_AD}};
        cs_sync[i]   <= {N_CS{IDLE_CS_N}};
        rw_sync[i]   <= IDLE_RW;
        phi2_sync[i] <= IDLE_PHI2;
      end
    end else begin
      d_sync[0]    <= bus_d;
      a_sync[0]    <= bus_a;
      cs_sync[0]   <= bus_cs_n;
      rw_sync[0]   <= bus_rw;
      phi2_sync[0] <= bus_phi2;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        d_sync[i]    <= d_sync[i-1];
        a_sync[i]    <= a_sync[i-1];
        cs_sync[i]   <= cs_sync[i-1];
        rw_sync[i]   <= rw_sync[i-1];
        phi2_sync[i] <= phi2_sync[i-1];
      end
    end
  end

  logic [DATA_W-1:0] s_d;
  logic [ADDR_W-1:0] s_a;
  logic [N_CS-1:0]   s_cs_n;
  logic              s_rw, s_phi2;

  assign s_d    = d_sync[SYNC_STAGES-1];
  assign s_a    = a_sync[SYNC_STAGES-1];
  assign s_cs_n = cs_sync[SYNC_STAGES-1];
  assign s_rw   = rw_sync[SYNC_STAGES-1];
  assign s_phi2 = phi2_sync[SYNC_STAGES-1];

  // Edges are honoured only once the chain holds real pin samples and phi2 has been
  // seen low, so a phi2 cycle cut by reset cannot produce a commit.
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   primed_q, h_phi2_q, in_cycle_q;
  logic                   rise, fall, phi2_hi;

  assign rise    = primed_q & s_phi2 & ~h_phi2_q;
  assign fall    = in_cycle_q & ~s_phi2 & h_phi2_q;
  assign phi2_hi = s_phi2 & (rise | in_cycle_q);

  logic [N_CS-1:0]   cs_low;
  logic [CHIP_W-1:0] chip;
  logic              sel, multi;

  always_comb begin
    cs_low = ~s_cs_n;
    sel    = |cs_low;
    multi  = |(cs_low & (cs_low - N_CS'(1)));
    chip   = '0;
    for (int i = int'(N_CS) - 1; i >= 0; i--) begin
      if (cs_low[i]) chip = CHIP_W'(i);
    end
  end

  logic          commit, push, pop, fifo_full, fifo_empty;
  logic [EW-1:0] fifo_din, fifo_dout;

  assign commit   = fall & sel;
  assign push     = commit & ~s_rw;
  assign pop      = wr_valid & wr_ready;
  assign fifo_din = {chip, s_a, s_d};

  sid_wr_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (fifo_din),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign wr_valid = ~fifo_empty;
  assign wr_chip  = fifo_dout[CL +: CHIP_W];
  assign wr_addr  = fifo_dout[AL +: ADDR_W];
  assign wr_data  = fifo_dout[0 +: DATA_W];

  logic              clken_q, oe_q, oe_d, overflow_q, conflict_q;
  logic [CHIP_W-1:0] rd_chip_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] d_out_q;

  assign oe_d = phi2_hi & sel & s_rw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q     <= '0;
      primed_q   <= 1'b0;
      h_phi2_q   <= IDLE_PHI2;
      in_cycle_q <= 1'b0;
      clken_q    <= 1'b0;
      oe_q       <= 1'b0;
      d_out_q    <= '0;
      rd_chip_q  <= '0;
      rd_addr_q  <= '0;
      overflow_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      h_phi2_q <= s_phi2;
      if (fill_q[SYNC_STAGES-1] && !s_phi2) primed_q <= 1'b1;
      if (rise)      in_cycle_q <= 1'b1;
      else if (fall) in_cycle_q <= 1'b0;
      clken_q <= rise;
      oe_q    <= oe_d;
      if (oe_d) d_out_q <= rd_data;
      if (sel && s_rw) begin
        rd_chip_q <= chip;
        rd_addr_q <= s_a;
      end
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      if (commit && multi)           conflict_q <= 1'b1;
    end
  end

  assign clken       = clken_q;
  assign bus_d_oe    = oe_q;
  assign bus_d_out   = d_out_q;
  assign rd_chip     = rd_chip_q;
  assign rd_addr     = rd_addr_q;
  assign overflow    = overflow_q;
  assign cs_conflict = conflict_q;

endmodule

// File: tb/tb_sid_bus_if.sv
// Directed bench for sid_bus_if: clock enable, write queue, conflict, overflow,
// pop-then-push, read path and reset in the middle of a bus cycle.
module tb_sid_bus_if;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_d;
  logic [4:0] bus_a;
  logic [1:0] bus_cs_n;
  logic       bus_rw, bus_phi2;
  logic       clken, wr_valid, wr_ready;
  logic [0:0] wr_chip, rd_chip;
  logic [4:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data, bus_d_out;
  logic       bus_d_oe, overflow, cs_conflict;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sid_bus_if dut (
    .clk        (clk),
    .rst        (rst),
    .bus_d      (bus_d),
    .bus_a      (bus_a),
    .bus_cs_n   (bus_cs_n),
    .bus_rw     (bus_rw),
    .bus_phi2   (bus_phi2),
    .clken      (clken),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_chip    (wr_chip),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_chip    (rd_chip),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .bus_d_out  (bus_d_out),
    .bus_d_oe   (bus_d_oe),
    .overflow   (overflow),
    .cs_conflict(cs_conflict)
  );

  typedef struct {
    logic [1:0] cs_n;
    logic [4:0] a;
    logic [7:0] d;
    logic [0:0] exp_chip;
    logic       exp_conflict;
  } wvec_t;

  wvec_t vecs [3];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Full phi2 cycle; rdy_at_fall raises wr_ready exactly on the commit cycle.
  task automatic bus_cycle(input logic [1:0] cs_n, input logic rw, input logic [4:0] a,
                           input logic [7:0] d, input logic rdy_at_fall);
    bus_cs_n = cs_n; bus_rw = rw; bus_a = a; bus_d = d;
    tick(4);
    bus_phi2 = 1'b1;
    tick(12);
    bus_phi2 = 1'b0;
    tick(2);
    wr_ready = rdy_at_fall;
    tick(1);
    wr_ready = 1'b0;
    tick(3);
    bus_cs_n = 2'b11; bus_rw = 1'b1;
    tick(2);
  endtask

  task automatic pop_one();
    wr_ready = 1'b1;
    tick(1);
    wr_ready = 1'b0;
  endtask

  initial begin
    int pulses, at_k;
    vecs[0] = '{cs_n: 2'b10, a: 5'h18, d: 8'h0F, exp_chip: 1'b0, exp_conflict: 1'b0};
    vecs[1] = '{cs_n: 2'b01, a: 5'h04, d: 8'h41, exp_chip: 1'b1, exp_conflict: 1'b0};
    vecs[2] = '{cs_n: 2'b00, a: 5'h07, d: 8'h33, exp_chip: 1'b0, exp_conflict: 1'b1};

    rst = 1'b1; bus_d = '0; bus_a = '0; bus_cs_n = 2'b11; bus_rw = 1'b1;
    bus_phi2 = 1'b0; wr_ready = 1'b0; rd_data = '0;
    tick(3);
    rst = 1'b0;
    chk("reset wr_valid", 32'(wr_valid), 0);
    chk("reset bus_d_oe", 32'(bus_d_oe), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset cs_conflict", 32'(cs_conflict), 0);
    chk("reset rd_addr", 32'(rd_addr), 0);
    chk("reset bus_d_out", 32'(bus_d_out), 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (clken) pulses++;
    end
    chk("no clken after reset", 32'(pulses), 0);

    // Clock enable: one pulse SYNC_STAGES+1 cycles after each rise, none on the low half.
    for (int p = 0; p < 3; p++) begin
      bus_phi2 = 1'b1;
      pulses = 0; at_k = -1;
      for (int k = 1; k <= 24; k++) begin
        tick(1);
        if (clken) begin pulses++; at_k = k; end
      end
      chk("clken count high half", 32'(pulses), 1);
      chk("clken latency", 32'(at_k), 3);
      bus_phi2 = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 24; k++) begin
        tick(1);
        if (clken) pulses++;
      end
      chk("clken count low half", 32'(pulses), 0);
    end

    for (int i = 0; i < 3; i++) begin
      bus_cycle(vecs[i].cs_n, 1'b0, vecs[i].a, vecs[i].d, 1'b0);
      chk("vec wr_valid", 32'(wr_valid), 1);
      chk("vec wr_chip", 32'(wr_chip), 32'(vecs[i].exp_chip));
      chk("vec wr_addr", 32'(wr_addr), 32'(vecs[i].a));
      chk("vec wr_data", 32'(wr_data), 32'(vecs[i].d));
      chk("vec cs_conflict", 32'(cs_conflict), 32'(vecs[i].exp_conflict));
      pop_one();
      chk("vec popped", 32'(wr_valid), 0);
    end

    // Backpressure: five writes into a four-entry queue.
    for (int k = 1; k <= 5; k++) bus_cycle(2'b10, 1'b0, 5'(k), 8'(k), 1'b0);
    chk("overflow set", 32'(overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf queued valid", 32'(wr_valid), 1);
      chk("ovf queued data", 32'(wr_data), k);
      chk("ovf queued addr", 32'(wr_addr), k);
      pop_one();
    end
    chk("ovf fifth lost", 32'(wr_valid), 0);

    // Read cycle.
    bus_cs_n = 2'b10; bus_rw = 1'b1; bus_a = 5'h1B; rd_data = 8'hA5;
    tick(6);
    chk("read rd_addr", 32'(rd_addr), 32'h1B);
    chk("read rd_chip", 32'(rd_chip), 0);
    chk("read oe before phi2", 32'(bus_d_oe), 0);
    bus_phi2 = 1'b1;
    tick(4);
    chk("read oe", 32'(bus_d_oe), 1);
    chk("read bus_d_out", 32'(bus_d_out), 32'hA5);
    bus_phi2 = 1'b0;
    tick(2);
    chk("read oe at synced fall", 32'(bus_d_oe), 1);
    tick(1);
    chk("read oe dropped", 32'(bus_d_oe), 0);
    chk("read no push", 32'(wr_valid), 0);
    chk("read d_out held", 32'(bus_d_out), 32'hA5);
    bus_cs_n = 2'b11;
    tick(2);

    // Reset while phi2 is high with a write already queued.
    bus_cycle(2'b10, 1'b0, 5'h0A, 8'h77, 1'b0);
    chk("pre-reset queued", 32'(wr_valid), 1);
    bus_cs_n = 2'b10; bus_rw = 1'b0; bus_a = 5'h0C; bus_d = 8'hEE;
    tick(4);
    bus_phi2 = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(2);
    chk("midrst wr_valid", 32'(wr_valid), 0);
    chk("midrst overflow", 32'(overflow), 0);
    chk("midrst cs_conflict", 32'(cs_conflict), 0);
    rst = 1'b0;
    tick(10);
    bus_phi2 = 1'b0;
    tick(8);
    chk("partial cycle ignored", 32'(wr_valid), 0);
    bus_cs_n = 2'b11; bus_rw = 1'b1;
    tick(2);
    bus_cycle(2'b10, 1'b0, 5'h0D, 8'h5A, 1'b0);
    chk("post-reset valid", 32'(wr_valid), 1);
    chk("post-reset addr", 32'(wr_addr), 32'h0D);
    chk("post-reset data", 32'(wr_data), 32'h5A);
    pop_one();

    // Full queue with a pop on the commit cycle: pop-then-push.
    for (int k = 0; k < 4; k++) bus_cycle(2'b10, 1'b0, 5'(k), 8'(8'h11 + k), 1'b0);
    chk("full no overflow yet", 32'(overflow), 0);
    bus_cycle(2'b10, 1'b0, 5'h04, 8'h15, 1'b1);
    chk("pop-then-push no overflow", 32'(overflow), 0);
    for (int k = 0; k < 4; k++) begin
      chk("ptp data", 32'(wr_data), 32'(8'h12 + k));
      pop_one();
    end
    chk("ptp drained", 32'(wr_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
